// File: rtl/nes_joypad_pkg.sv
// ============================================================================
// nes_joypad_pkg : button/keycode tables, shifter states and mapping helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package nes_joypad_pkg;

  typedef enum logic [2:0] {
    BTN_A      = 3'd0,
    BTN_B      = 3'd1,
    BTN_SELECT = 3'd2,
    BTN_START  = 3'd3,
    BTN_UP     = 3'd4,
    BTN_DOWN   = 3'd5,
    BTN_LEFT   = 3'd6,
    BTN_RIGHT  = 3'd7
  } btn_e;

  typedef logic [7:0][7:0] key_table_t;

  // Index n holds the HID keycode for button bit n (MSB entry = Right)
  localparam key_table_t P1_KEYS = {8'h07, 8'h04, 8'h16, 8'h1A, 8'h0B, 8'h0A, 8'h0E, 8'h0D};
  localparam key_table_t P2_KEYS = {8'h4F, 8'h50, 8'h51, 8'h52, 8'h28, 8'h2D, 8'h36, 8'h37};

  localparam int unsigned NUM_SLOTS = 6;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_EMPTY = 2'd2
  } shifter_state_e;

  function automatic logic [7:0] map_keys(input logic [47:0] keys, input key_table_t tbl);
    logic [7:0] btn;
    btn = '0;
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (keys[8*s +: 8] == tbl[b]) btn[b] = 1'b1;
      end
    end
    return btn;
  endfunction

  function automatic logic [7:0] mask_opposite(input logic [7:0] btn);
    logic [7:0] m;
    m = btn;
    if (btn[BTN_UP] && btn[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end
    if (btn[BTN_LEFT] && btn[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nes_joypad_shifter.sv
// ============================================================================
// nes_joypad_shifter : one controller's latch / serial shift register
// Rev 1.0
// ============================================================================
`default_nettype none

module nes_joypad_shifter
  import nes_joypad_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] buttons_i,
  input  logic       strobe_i,
  input  logic       rd_i,
  output logic       serial_o
);

  shifter_state_e state_q, state_d;
  logic [7:0]     sr_q, sr_d;
  logic [3:0]     cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      sr_q    <= 8'hFF;
      cnt_q   <= 4'd8;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    if (strobe_i) begin
      state_d = ST_LOAD;
      sr_d    = buttons_i;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        // LOAD with strobe low is the first shift cycle after the latch closed
        ST_LOAD, ST_SHIFT: begin
          state_d = ST_SHIFT;
          if (rd_i) begin
            sr_d  = {1'b1, sr_q[7:1]};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) state_d = ST_EMPTY;
          end
        end
        ST_EMPTY: begin
          sr_d  = 8'hFF;
          cnt_d = 4'd8;
        end
        default: begin
          state_d = ST_EMPTY;
          sr_d    = 8'hFF;
          cnt_d   = 4'd8;
        end
      endcase
    end
  end

  assign serial_o = strobe_i ? buttons_i[0] : sr_q[0];

endmodule

`default_nettype wire

// File: rtl/nes_joypad_port.sv
// ============================================================================
// nes_joypad_port : NES $4016/$4017 controller ports driven from USB keycodes
// Rev 1.0
// ============================================================================
`default_nettype none

module nes_joypad_port
  import nes_joypad_pkg::*;
#(
  parameter bit         ALLOW_OPPOSITE = 1'b0,
  parameter logic [7:0] OPEN_BUS       = 8'h40
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [47:0] keycodes,
  input  logic        cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  buttons_p1,
  output logic [7:0]  buttons_p2,
  output logic        strobe
);

  logic [47:0] keycodes_q;
  logic [7:0]  btn1_q, btn2_q, btn1_d, btn2_d;
  logic        strobe_q, strobe_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        strobe_set, rd1, rd2, ser1, ser2;
  logic        unused_wdata;

  assign unused_wdata = ^cpu_wdata[7:1];

  always_comb begin
    btn1_d = map_keys(keycodes_q, P1_KEYS);
    btn2_d = map_keys(keycodes_q, P2_KEYS);
    if (!ALLOW_OPPOSITE) begin
      btn1_d = mask_opposite(btn1_d);
      btn2_d = mask_opposite(btn2_d);
    end
  end

  // A read coinciding with a strobe-setting write must not shift
  assign strobe_set = cpu_wr & ~cpu_addr & cpu_wdata[0];
  assign rd1        = cpu_rd & ~cpu_addr & ~strobe_set;
  assign rd2        = cpu_rd &  cpu_addr & ~strobe_set;

  always_comb begin
    strobe_d = strobe_q;
    rdata_d  = rdata_q;
    if (cpu_wr && !cpu_addr) strobe_d = cpu_wdata[0];
    if (cpu_rd) rdata_d = {OPEN_BUS[7:1], cpu_addr ? ser2 : ser1};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      keycodes_q <= '0;
      btn1_q     <= '0;
      btn2_q     <= '0;
      strobe_q   <= 1'b0;
      rdata_q    <= {OPEN_BUS[7:1], 1'b0};
    end else begin
      keycodes_q <= keycodes;
      btn1_q     <= btn1_d;
      btn2_q     <= btn2_d;
      strobe_q   <= strobe_d;
      rdata_q    <= rdata_d;
    end
  end

  nes_joypad_shifter u_p1 (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .buttons_i (btn1_q),
    .strobe_i  (strobe_q),
    .rd_i      (rd1),
    .serial_o  (ser1)
  );

  nes_joypad_shifter u_p2 (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .buttons_i (btn2_q),
    .strobe_i  (strobe_q),
    .rd_i      (rd2),
    .serial_o  (ser2)
  );

  assign cpu_rdata  = rdata_q;
  assign buttons_p1 = btn1_q;
  assign buttons_p2 = btn2_q;
  assign strobe     = strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_joypad_port.sv
// ============================================================================
// tb_nes_joypad_port : scoreboard bench with a queue-based controller model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_nes_joypad_port;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [47:0] keycodes = '0;
  logic        cpu_addr = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata, buttons_p1, buttons_p2;
  logic        strobe;
  logic [7:0]  ao_rdata, ao_p1, ao_p2;
  logic        ao_strobe;

  nes_joypad_port #(.ALLOW_OPPOSITE(1'b0), .OPEN_BUS(8'h40)) dut (
    .Clk(Clk), .Reset(Reset), .keycodes(keycodes), .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .buttons_p1(buttons_p1), .buttons_p2(buttons_p2),
    .strobe(strobe)
  );

  nes_joypad_port #(.ALLOW_OPPOSITE(1'b1), .OPEN_BUS(8'h40)) dut_ao (
    .Clk(Clk), .Reset(Reset), .keycodes(keycodes), .cpu_addr(cpu_addr),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(ao_rdata), .buttons_p1(ao_p1), .buttons_p2(ao_p2),
    .strobe(ao_strobe)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  byte unsigned P1K [8] = '{8'h0D, 8'h0E, 8'h0A, 8'h0B, 8'h1A, 8'h16, 8'h04, 8'h07};
  byte unsigned P2K [8] = '{8'h37, 8'h36, 8'h2D, 8'h28, 8'h52, 8'h51, 8'h50, 8'h4F};

  // Controller model: strobe level, settled button bytes, pending serial bits
  bit         m_strobe = 1'b0;
  logic [7:0] m_b1 = '0, m_b2 = '0;
  bit         q1 [$];
  bit         q2 [$];
  logic [7:0] sb [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_buttons(input logic [47:0] k, input bit allow,
                               output logic [7:0] b1, output logic [7:0] b2);
    byte unsigned code;
    b1 = '0;
    b2 = '0;
    for (int s = 0; s < 6; s++) begin
      code = k[8*s +: 8];
      for (int i = 0; i < 8; i++) begin
        if (code == P1K[i]) b1[i] = 1'b1;
        if (code == P2K[i]) b2[i] = 1'b1;
      end
    end
    if (!allow) begin
      if (b1[4] && b1[5]) b1[5:4] = 2'b00;
      if (b1[6] && b1[7]) b1[7:6] = 2'b00;
      if (b2[4] && b2[5]) b2[5:4] = 2'b00;
      if (b2[6] && b2[7]) b2[7:6] = 2'b00;
    end
  endtask

  // Monitor: a read accepted at a rising edge is visible by the falling edge
  logic rd_seen = 1'b0;
  always @(posedge Clk) rd_seen <= cpu_rd;

  initial forever begin
    @(negedge Clk);
    if (rd_seen) begin
      if (sb.size() == 0) check("sb_underflow", cpu_rdata, 8'hxx);
      else check("rdata", cpu_rdata, sb.pop_front());
    end
  end

  task automatic do_op(input bit rd, input bit wr, input bit addr, input logic [7:0] wd);
    bit exp_bit, set_now;
    set_now = wr && !addr && wd[0];
    if (rd) begin
      if (m_strobe) exp_bit = addr ? m_b2[0] : m_b1[0];
      else if (!addr) begin
        if (q1.size() == 0) exp_bit = 1'b1;
        else begin
          exp_bit = q1[0];
          if (!set_now) void'(q1.pop_front());
        end
      end else begin
        if (q2.size() == 0) exp_bit = 1'b1;
        else begin
          exp_bit = q2[0];
          if (!set_now) void'(q2.pop_front());
        end
      end
      sb.push_back({7'h20, exp_bit});
    end
    if (wr && !addr) begin
      if (m_strobe && !wd[0]) begin
        q1.delete();
        q2.delete();
        for (int i = 0; i < 8; i++) begin
          q1.push_back(m_b1[i]);
          q2.push_back(m_b2[i]);
        end
      end
      m_strobe = wd[0];
    end
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    @(posedge Clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    check("strobe", {7'd0, strobe}, {7'd0, m_strobe});
  endtask

  task automatic rd_port(input bit addr);
    do_op(1'b1, 1'b0, addr, 8'h00);
  endtask

  task automatic wr_strobe(input bit v);
    do_op(1'b0, 1'b1, 1'b0, {7'd0, v});
  endtask

  task automatic set_keys(input logic [47:0] k);
    logic [7:0] o1, o2, n1, n2, a1, a2;
    o1 = m_b1; o2 = m_b2;
    model_buttons(k, 1'b0, n1, n2);
    model_buttons(k, 1'b1, a1, a2);
    keycodes = k;
    @(posedge Clk); #1;
    check("p1_latency", buttons_p1, o1);
    check("p2_latency", buttons_p2, o2);
    @(posedge Clk); #1;
    check("buttons_p1", buttons_p1, n1);
    check("buttons_p2", buttons_p2, n2);
    check("ao_buttons_p1", ao_p1, a1);
    check("ao_buttons_p2", ao_p2, a2);
    m_b1 = n1; m_b2 = n2;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    #6;
    Reset = 1'b1;
    #1;
    check("rst_rdata", cpu_rdata, 8'h40);
    check("rst_strobe", {7'd0, strobe}, 8'h00);
    check("rst_p1", buttons_p1, 8'h00);
    check("rst_p2", buttons_p2, 8'h00);
    m_strobe = 1'b0;
    q1.delete();
    q2.delete();
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
  endtask

  function automatic logic [47:0] rand_keys();
    logic [47:0] k;
    int r;
    k = '0;
    for (int s = 0; s < 6; s++) begin
      r = $urandom_range(0, 3);
      if (r < 2) k[8*s +: 8] = ($urandom_range(0, 1) != 0) ? P1K[$urandom_range(0, 7)]
                                                           : P2K[$urandom_range(0, 7)];
      else if (r == 3) k[8*s +: 8] = 8'($urandom);
    end
    return k;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    @(posedge Clk); #1;
    do_reset();

    rd_port(1'b0);
    rd_port(1'b0);

    set_keys({8'h00, 8'h00, 8'h0B, 8'h00, 8'h00, 8'h0D});
    check("p1_JH", buttons_p1, 8'h09);
    wr_strobe(1'b1);
    wr_strobe(1'b0);
    repeat (9) rd_port(1'b0);

    set_keys({8'h00, 8'h00, 8'h00, 8'h00, 8'h51, 8'h52});
    check("p2_updown_mask", buttons_p2, 8'h00);
    check("p2_updown_allow", ao_p2, 8'h30);

    set_keys({8'h00, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h0D});
    wr_strobe(1'b1);
    repeat (5) rd_port(1'b0);
    wr_strobe(1'b0);
    rd_port(1'b0);
    rd_port(1'b0);

    set_keys({8'h00, 8'h00, 8'h00, 8'h00, 8'h4F, 8'h0D});
    wr_strobe(1'b1);
    wr_strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      rd_port(1'b0);
      rd_port(1'b1);
    end

    set_keys({8'h00, 8'h00, 8'h00, 8'h0A, 8'h0E, 8'h0D});
    wr_strobe(1'b1);
    wr_strobe(1'b0);
    repeat (3) rd_port(1'b0);
    do_reset();
    rd_port(1'b0);
    wr_strobe(1'b1);
    wr_strobe(1'b0);
    repeat (9) rd_port(1'b0);

    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       set_keys(rand_keys());
      else if (r < 18) wr_strobe(1'($urandom_range(0, 1)));
      else if (r < 21) do_op(1'b0, 1'b1, 1'b1, 8'($urandom));
      else if (r < 30) do_op(1'b1, 1'b1, 1'b0, {7'($urandom), 1'($urandom_range(0, 1))});
      else if (r < 32) do_reset();
      else if (r < 36) begin @(posedge Clk); #1; end
      else             rd_port(1'($urandom_range(0, 1)));
    end

    repeat (2) begin @(posedge Clk); #1; end
    check("sb_empty", 8'(sb.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nes_joypad_port.md
Name: nes_joypad_port

Overview:
Emulates the two NES standard-controller serial ports ($4016/$4017) for the CPU core. Its input is the six USB HID keycodes that the NIOS software exports through the keycode1/keycode2 PIOs. It maps those keycodes to two 8-button states and implements the strobe/latch/serial-shift protocol. It sits between the USB keycode PIOs and the NES CPU memory-mapped I/O decode.

Parameters:
ALLOW_OPPOSITE, 0, when 0 Up+Down or Left+Right pressed together clears both bits of that pair
OPEN_BUS, 8'h40, value driven on cpu_rdata[7:1]; bit 0 is always the serial data

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous active-high reset
keycodes  in  48  six packed 8-bit USB HID keycodes ({keycode2, keycode1}); 0x00 = none
cpu_addr  in  1  0 = $4016 (player 1), 1 = $4017 (player 2)
cpu_rd  in  1  one-cycle read pulse
cpu_wr  in  1  one-cycle write pulse (only meaningful when cpu_addr = 0)
cpu_wdata  in  8  write data; bit 0 = strobe
cpu_rdata  out  8  read data, registered
buttons_p1  out  8  live mapped P1 buttons, for HEX/debug
buttons_p2  out  8  live mapped P2 buttons
strobe  out  1  current strobe latch

Behaviour:
- Button byte order is NES order: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right. 1 = pressed.
- P1 mapping: J=0x0D A, K=0x0E B, G=0x0A Select, H=0x0B Start, W=0x1A Up, S=0x16 Down, A=0x04 Left, D=0x07 Right.
- P2 mapping: .=0x37 A, ,=0x36 B, -=0x2D Select, Enter=0x28 Start, 0x52 Up, 0x51 Down, 0x50 Left, 0x4F Right.
- A button is pressed if any of the six keycode slots equals its code. Duplicate slots are harmless.
- keycodes is registered once. buttons_p1/p2 are registered from the mapped value, so a keycode change appears on buttons_* 2 cycles later.
- Opposite-direction masking is applied before buttons_* when ALLOW_OPPOSITE = 0.
- Strobe: a write with cpu_addr=0 sets strobe <= cpu_wdata[0] on the next edge. A write with cpu_addr=1 is ignored (APU frame counter, decoded elsewhere).
- Each port has a shifter with an 8-bit shift register sr and a 4-bit saturating counter cnt. Per-port FSM:
  - LOAD (strobe=1): sr <= buttons every cycle; cnt <= 0.
  - SHIFT (strobe=0, cnt<8): a read of that port shifts sr right with a 1 filled into bit 7, and cnt++.
  - EMPTY (cnt=8): reads return 1 and cnt holds at 8.
  - Transitions: strobe 1->0 goes LOAD->SHIFT, holding the last loaded value. Strobe 0->1 from any state goes to LOAD.
- Read data: cpu_rdata <= {OPEN_BUS[7:1], sr[0]} of the addressed port, one cycle after cpu_rd. It holds until the next read.
- Read with strobe=1 returns the live A bit and does not shift.
- A write and a read in the same cycle: the read samples pre-edge sr. The strobe write takes effect on the same edge. If the strobe is set, the shift is suppressed.
- A read of one port never disturbs the other port.
- Reset values: strobe=0, sr=8'hFF, cnt=8 (EMPTY), cpu_rdata={OPEN_BUS[7:1],1'b0}, buttons_*=0, keycode register=0.
- Reset mid-sequence returns both ports to EMPTY immediately, regardless of strobe.

Decomposition:
- Package nes_joypad_pkg holds:
  - the button-index enum (BTN_A..BTN_RIGHT);
  - the P1/P2 keycode constant arrays (8 x 8-bit each);
  - the shifter FSM state enum (LOAD, SHIFT, EMPTY);
  - a function mapping 48-bit keycodes plus a keycode table to an 8-bit button byte.
- One sub-module, nes_joypad_shifter, instantiated twice. It contains sr, cnt and the FSM. Its inputs are buttons, strobe and a read pulse; its output is the serial bit.

Test Plan:
- Reset, then read $4016 twice -> cpu_rdata = 8'h41 both times (EMPTY returns 1).
- keycodes byte0=0x0D (J) and byte3=0x0B (H); write $4016=1, then $4016=0; 9 reads of $4016 -> bit0 sequence 1,0,0,1,0,0,0,0,1. buttons_p1 = 8'h09.
- Keys 0x52 and 0x51 held, ALLOW_OPPOSITE=0 -> buttons_p2 = 8'h00. With ALLOW_OPPOSITE=1 -> 8'h30.
- Strobe held at 1 with P1 A pressed; 5 reads -> all return 8'h41. After strobe goes to 0, the first read still returns 1 (A) and the second returns the B bit.
- Interleaved reads: P1 = 8'h01, P2 = 8'h80; latch, then alternate reads $4016/$4017 8 times each -> P1 gives 1,0,0,0,0,0,0,0 and P2 gives 0,0,0,0,0,0,0,1, with no cross-talk.
- Reset asserted after 3 reads of a latched sequence -> the next read returns 8'h41. After a new strobe the sequence restarts from A.
